// File: rtl/chip_io_pkg.sv
// Shared constants for the chip_io pad wrapper: default widths and the
// tri-state pad-mode encoding used by the GPIO resolution mux.
package chip_io_pkg;

   localparam int GPIO_W_DEF      = 16;
   localparam int SYNC_STAGES_DEF = 2;

   localparam logic PAD_DRIVE    = 1'b0;
   localparam logic PAD_TRISTATE = 1'b1;

endpackage : chip_io_pkg

// File: rtl/chip_io_if.sv
// Pin-side bundle of chip_io: raw SPI/GPIO pins toward the chip and their
// conditioned copies back to the core.
interface chip_io_if #(
   parameter int GPIO_W = chip_io_pkg::GPIO_W_DEF
);

   logic              spi_clk;
   logic              spi_en;
   logic              miso;
   logic              mosi;
   logic [GPIO_W-1:0] gpio_ts;
   logic [GPIO_W-1:0] gpio_dr;
   logic [GPIO_W-1:0] gpio_input;

   logic              spi_clk_out;
   logic              spi_en_out;
   logic              miso_out;
   logic              mosi_out;
   logic [GPIO_W-1:0] gpio_ps;

   // master drives the pins and observes the conditioned results
   modport master (
      output spi_clk, spi_en, miso, mosi, gpio_ts, gpio_dr, gpio_input,
      input  spi_clk_out, spi_en_out, miso_out, mosi_out, gpio_ps
   );

   modport slave (
      input  spi_clk, spi_en, miso, mosi, gpio_ts, gpio_dr, gpio_input,
      output spi_clk_out, spi_en_out, miso_out, mosi_out, gpio_ps
   );

endinterface : chip_io_if

// File: rtl/chip_io_sync.sv
// io_sync: per-bit multi-flop synchronizer chain with asynchronous
// active-low clear; q is the last stage of each bit's chain.
module io_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '0;
      end else begin
         stage[0] <= d;
         for (int s = 1; s < STAGES; s++) begin
            stage[s] <= stage[s-1];
         end
      end
   end

   assign q = stage[STAGES-1];

endmodule : io_sync

// File: rtl/chip_io.sv
// chip_io: pad wrapper that buffers clk, synchronizes the SPI pins and
// resolves the tri-statable GPIO pads from synchronized ts/dr/input values.
module chip_io
   import chip_io_pkg::*;
#(
   parameter int GPIO_W      = GPIO_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              clk_out,
   input  logic              spi_clk,
   output logic              spi_clk_out,
   input  logic              spi_en,
   output logic              spi_en_out,
   input  logic              miso,
   output logic              miso_out,
   input  logic              mosi,
   output logic              mosi_out,
   output logic [GPIO_W-1:0] gpio_ps,
   input  logic [GPIO_W-1:0] gpio_ts,
   input  logic [GPIO_W-1:0] gpio_dr,
   input  logic [GPIO_W-1:0] gpio_input
);

   logic [GPIO_W-1:0] ts_s;
   logic [GPIO_W-1:0] dr_s;
   logic [GPIO_W-1:0] in_s;

   assign clk_out = clk;

   io_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_spi_clk (
      .clk(clk), .rst_n(rst_n), .d(spi_clk), .q(spi_clk_out)
   );

   io_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_spi_en (
      .clk(clk), .rst_n(rst_n), .d(spi_en), .q(spi_en_out)
   );

   io_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_miso (
      .clk(clk), .rst_n(rst_n), .d(miso), .q(miso_out)
   );

   io_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_out)
   );

   // ts, dr and input share one depth so a pad's mode and value stay coherent
   io_sync #(.WIDTH(GPIO_W), .STAGES(SYNC_STAGES)) u_sync_ts (
      .clk(clk), .rst_n(rst_n), .d(gpio_ts), .q(ts_s)
   );

   io_sync #(.WIDTH(GPIO_W), .STAGES(SYNC_STAGES)) u_sync_dr (
      .clk(clk), .rst_n(rst_n), .d(gpio_dr), .q(dr_s)
   );

   io_sync #(.WIDTH(GPIO_W), .STAGES(SYNC_STAGES)) u_sync_in (
      .clk(clk), .rst_n(rst_n), .d(gpio_input), .q(in_s)
   );

   always_comb begin
      gpio_ps = '0;
      for (int i = 0; i < GPIO_W; i++) begin
         gpio_ps[i] = (ts_s[i] == PAD_TRISTATE) ? in_s[i] : dr_s[i];
      end
   end

endmodule : chip_io

// File: tb/tb_chip_io.sv
// Self-checking bench for chip_io: table of pin vectors with a scoreboard of
// expected conditioned outputs, plus hand sequences for reset and clk_out.
module tb_chip_io;

   localparam int GPIO_W = 16;

   typedef struct {
      logic [3:0]        spi;
      logic [GPIO_W-1:0] ts;
      logic [GPIO_W-1:0] dr;
      logic [GPIO_W-1:0] inp;
      logic [3:0]        exp_spi;
      logic [GPIO_W-1:0] exp_ps;
   } vec_t;

   typedef struct {
      logic [3:0]        spi;
      logic [GPIO_W-1:0] ps;
   } exp_t;

   logic clk;
   logic rst_n;
   logic clk_out;

   int checks;
   int failures;

   exp_t scoreboard[$];
   exp_t prev;
   vec_t vecs[$];

   chip_io_if #(.GPIO_W(GPIO_W)) pins ();

   chip_io #(.GPIO_W(GPIO_W), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_out     (clk_out),
      .spi_clk     (pins.spi_clk),
      .spi_clk_out (pins.spi_clk_out),
      .spi_en      (pins.spi_en),
      .spi_en_out  (pins.spi_en_out),
      .miso        (pins.miso),
      .miso_out    (pins.miso_out),
      .mosi        (pins.mosi),
      .mosi_out    (pins.mosi_out),
      .gpio_ps     (pins.gpio_ps),
      .gpio_ts     (pins.gpio_ts),
      .gpio_dr     (pins.gpio_dr),
      .gpio_input  (pins.gpio_input)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [3:0] spiOut();
      return {pins.spi_clk_out, pins.spi_en_out, pins.miso_out, pins.mosi_out};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      @(negedge clk);
      {pins.spi_clk, pins.spi_en, pins.miso, pins.mosi} = v.spi;
      pins.gpio_ts    = v.ts;
      pins.gpio_dr    = v.dr;
      pins.gpio_input = v.inp;
      e.spi = v.exp_spi;
      e.ps  = v.exp_ps;
      scoreboard.push_back(e);
   endtask

   task automatic checkLatency(input string name);
      exp_t e;
      @(posedge clk);
      #1;
      checkOutput({name, " early spi"}, 32'(spiOut()), 32'(prev.spi));
      checkOutput({name, " early ps"}, 32'(pins.gpio_ps), 32'(prev.ps));
      @(posedge clk);
      #1;
      if (scoreboard.size() == 0) begin
         checkOutput({name, " scoreboard empty"}, 32'd0, 32'd1);
      end else begin
         e = scoreboard.pop_front();
         checkOutput({name, " spi"}, 32'(spiOut()), 32'(e.spi));
         checkOutput({name, " ps"}, 32'(pins.gpio_ps), 32'(e.ps));
         prev = e;
      end
   endtask

   task automatic addVec(input logic [3:0] spi, input logic [15:0] ts,
                         input logic [15:0] dr, input logic [15:0] inp,
                         input logic [3:0] exp_spi, input logic [15:0] exp_ps);
      vec_t v;
      v.spi = spi; v.ts = ts; v.dr = dr; v.inp = inp;
      v.exp_spi = exp_spi; v.exp_ps = exp_ps;
      vecs.push_back(v);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      prev.spi = '0;
      prev.ps  = '0;

      // spi field order is {spi_clk, spi_en, miso, mosi}
      addVec(4'b1000, 16'h0000, 16'h0001, 16'hFFFF, 4'b1000, 16'h0001);
      addVec(4'b1100, 16'h0000, 16'h0000, 16'hFFFF, 4'b1100, 16'h0000);
      addVec(4'b1110, 16'h0001, 16'h0000, 16'h0001, 4'b1110, 16'h0001);
      addVec(4'b1111, 16'h0001, 16'h0000, 16'h0000, 4'b1111, 16'h0000);
      addVec(4'b0101, 16'h0000, 16'h0001, 16'h0000, 4'b0101, 16'h0001);
      addVec(4'b1010, 16'hFFFF, 16'h0000, 16'h8001, 4'b1010, 16'h8001);
      addVec(4'b0000, 16'h0000, 16'h4002, 16'hFFFF, 4'b0000, 16'h4002);
      // A5 bits take input (FF00), the others take dr (0F0F)
      addVec(4'b0110, 16'hA5A5, 16'h0F0F, 16'hFF00, 4'b0110, 16'hAF0A);

      rst_n = 1'b0;
      pins.spi_clk = 1'b0; pins.spi_en = 1'b0; pins.miso = 1'b0; pins.mosi = 1'b0;
      pins.gpio_ts = '0; pins.gpio_dr = '0; pins.gpio_input = '0;

      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("clk_out high in reset", 32'(clk_out), 32'(clk));
         @(negedge clk); #1;
         checkOutput("clk_out low in reset", 32'(clk_out), 32'(clk));
      end
      checkOutput("reset spi", 32'(spiOut()), 32'd0);
      checkOutput("reset ps", 32'(pins.gpio_ps), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("clk_out high run", 32'(clk_out), 32'(clk));
         @(negedge clk); #1;
         checkOutput("clk_out low run", 32'(clk_out), 32'(clk));
      end

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkLatency($sformatf("vec%0d", i));
      end

      // short reset pulse between edges while gpio_ps = AF0A
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid reset spi", 32'(spiOut()), 32'd0);
      checkOutput("mid reset ps", 32'(pins.gpio_ps), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("mid release early ps", 32'(pins.gpio_ps), 32'd0);
      @(posedge clk); #1;
      checkOutput("mid release ps", 32'(pins.gpio_ps), 32'hAF0A);
      checkOutput("mid release spi", 32'(spiOut()), 32'b0110);

      // all pins high, then asynchronous reset with no edge in between
      begin
         vec_t v;
         v.spi = 4'b1111; v.ts = 16'hFFFF; v.dr = 16'h0000; v.inp = 16'hFFFF;
         v.exp_spi = 4'b1111; v.exp_ps = 16'hFFFF;
         applyStimulus(v);
         checkLatency("all ones");
      end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async reset spi", 32'(spiOut()), 32'd0);
      checkOutput("async reset ps", 32'(pins.gpio_ps), 32'd0);
      @(posedge clk); #1;
      checkOutput("held reset ps", 32'(pins.gpio_ps), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("release early spi", 32'(spiOut()), 32'd0);
      checkOutput("release early ps", 32'(pins.gpio_ps), 32'd0);
      @(posedge clk); #1;
      checkOutput("release spi", 32'(spiOut()), 32'b1111);
      checkOutput("release ps", 32'(pins.gpio_ps), 32'hFFFF);

      checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_chip_io
